// File: rtl/mac_pkg.sv
// Shared types and default widths for the mac_accum accumulate stage.
package mac_pkg;

  typedef enum logic {ACCUM, HOLD} mac_state_t;

  localparam int PW_DEF    = 16;
  localparam int AW_DEF    = 24;
  localparam int CNT_W_DEF = 10;

endpackage

// File: rtl/mac_accum_if.sv
// Product-in / result-out handshake bundle for mac_accum.
// master: product source and result consumer; slave: the accumulate stage.
interface mac_accum_if
  import mac_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    result;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output in_valid, prod, in_last, out_ready,
    input  in_ready, out_valid, result, count, ovf
  );

  modport slave (
    input  in_valid, prod, in_last, out_ready,
    output in_ready, out_valid, result, count, ovf
  );

endinterface

// File: rtl/mac_sat_add.sv
// AW-bit accumulator plus zero-extended product, with carry out of bit AW-1.
// Build option MAC_ACCUM_SAT_EN: clamp the sum to all-ones when it carries out;
// otherwise the sum wraps modulo 2^AW.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] full;

  assign full  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, prod};
  assign carry = full[AW];

`ifdef MAC_ACCUM_SAT_EN
  // Once clamped, any further non-zero term carries again, so the sum sticks at max.
  assign sum = carry ? {AW{1'b1}} : full[AW-1:0];
`else
  assign sum = full[AW-1:0];
`endif

endmodule

// File: rtl/mac_accum.sv
// Accumulate stage behind the 8x8 multiplier: sums a LAST-delimited vector of
// products and emits one result/count/overflow record per vector.
// Saturating accumulation is selected by MAC_ACCUM_SAT_EN (see mac_sat_add).
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | no result pending; products add into acc
// HOLD  | result/count/ovf valid and held until out_ready; non-LAST
//       | products of the next vector keep accumulating meanwhile
module mac_accum
  import mac_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_accum_if.slave   bus
);

  logic             s1_v;
  logic             s1_last;
  logic [PW-1:0]    s1_prod;

  mac_state_t       state;
  logic [AW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  logic             out_valid_q;
  logic [AW-1:0]    result_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic             s2_take;
  logic             in_ready;
  logic [AW-1:0]    sum;
  logic             carry;

  // A LAST term may only retire when the result register is free or being drained.
  assign s2_take  = s1_v && !(s1_last && out_valid_q && !bus.out_ready);
  assign in_ready = !s1_v || s2_take;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;

  mac_sat_add #(
    .PW (PW),
    .AW (AW)
  ) u_add (
    .acc   (acc),
    .prod  (s1_prod),
    .sum   (sum),
    .carry (carry)
  );

  // Stage 1 skid register; prod is only captured on a handshake so idle X never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
    end else if (in_ready) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_prod <= bus.prod;
        s1_last <= bus.in_last;
      end
    end
  end

  // Stage 2 FSM: accumulate, retire a vector into the output registers, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else if (s2_take && s1_last) begin
      // Retiring a LAST also covers the HOLD-with-handshake case: new result replaces old.
      result_q    <= sum;
      count_q     <= cnt + CNT_W'(1);
      ovf_q       <= ovf_acc | carry;
      out_valid_q <= 1'b1;
      acc         <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      state       <= HOLD;
    end else begin
      if (s2_take) begin
        acc     <= sum;
        cnt     <= cnt + CNT_W'(1);
        ovf_acc <= ovf_acc | carry;
      end
      case (state)
        ACCUM: ;
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
